// File: rtl/decode_stage.sv
`default_nettype none
// ============================================================================
// Module   : decode_stage
// Purpose  : Registered instruction decode; captures IR/NPC/PSR and produces
//            execute, writeback and memory control fields one cycle later.
// Revision : 1.0 - initial release
// ============================================================================
module decode_stage #(
    parameter bit ILLEGAL_AS_NOP = 1'b1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [15:0] instr_dout,
    input  logic [15:0] npc_in,
    input  logic [2:0]  Sr,
    input  logic        en_decode,
    output logic [15:0] IR,
    output logic [15:0] npc_out,
    output logic [2:0]  psr_out,
    output logic [5:0]  E_Control,
    output logic [1:0]  W_Control,
    output logic        Mem_Control,
    output logic        valid,
    output logic        illegal
);

    localparam logic [3:0] c_OP_BR  = 4'b0000;
    localparam logic [3:0] c_OP_ADD = 4'b0001;
    localparam logic [3:0] c_OP_LD  = 4'b0010;
    localparam logic [3:0] c_OP_ST  = 4'b0011;
    localparam logic [3:0] c_OP_AND = 4'b0101;
    localparam logic [3:0] c_OP_LDR = 4'b0110;
    localparam logic [3:0] c_OP_STR = 4'b0111;
    localparam logic [3:0] c_OP_NOT = 4'b1001;
    localparam logic [3:0] c_OP_LDI = 4'b1010;
    localparam logic [3:0] c_OP_STI = 4'b1011;
    localparam logic [3:0] c_OP_JMP = 4'b1100;
    localparam logic [3:0] c_OP_LEA = 4'b1110;

    localparam logic [1:0] c_WB_ALU = 2'd0;
    localparam logic [1:0] c_WB_MEM = 2'd1;
    localparam logic [1:0] c_WB_PC  = 2'd2;

    logic [3:0] w_opcode;
    logic [5:0] w_e_ctrl;
    logic [1:0] w_w_ctrl;
    logic       w_mem_ctrl;
    logic       w_illegal;
    logic       w_load_ctrl;

    assign w_opcode = instr_dout[15:12];

    always_comb begin
        w_e_ctrl   = 6'b000000;
        w_w_ctrl   = c_WB_ALU;
        w_mem_ctrl = 1'b0;
        w_illegal  = 1'b0;
        case (w_opcode)
            c_OP_ADD: w_e_ctrl = instr_dout[5] ? 6'b000000 : 6'b000001;
            c_OP_AND: w_e_ctrl = instr_dout[5] ? 6'b010000 : 6'b010001;
            c_OP_NOT: w_e_ctrl = 6'b100000;
            c_OP_BR, c_OP_ST: w_e_ctrl = 6'b000110;
            c_OP_LD: begin
                w_e_ctrl = 6'b000110;
                w_w_ctrl = c_WB_MEM;
            end
            c_OP_LDI: begin
                w_e_ctrl   = 6'b000110;
                w_w_ctrl   = c_WB_MEM;
                w_mem_ctrl = 1'b1;
            end
            c_OP_STI: begin
                w_e_ctrl   = 6'b000110;
                w_mem_ctrl = 1'b1;
            end
            c_OP_LEA: begin
                w_e_ctrl = 6'b000110;
                w_w_ctrl = c_WB_PC;
            end
            c_OP_LDR: begin
                w_e_ctrl = 6'b001000;
                w_w_ctrl = c_WB_MEM;
            end
            c_OP_STR: w_e_ctrl = 6'b001000;
            c_OP_JMP: w_e_ctrl = 6'b001100;
            default:  w_illegal = 1'b1;
        endcase
    end

    // Illegal opcodes either load the zeroed decode or leave controls untouched.
    assign w_load_ctrl = !w_illegal || ILLEGAL_AS_NOP;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            IR          <= 16'h0000;
            npc_out     <= 16'h0000;
            psr_out     <= 3'b000;
            E_Control   <= 6'b000000;
            W_Control   <= 2'd0;
            Mem_Control <= 1'b0;
            valid       <= 1'b0;
            illegal     <= 1'b0;
        end else if (en_decode) begin
            IR      <= instr_dout;
            npc_out <= npc_in;
            psr_out <= Sr;
            valid   <= 1'b1;
            illegal <= w_illegal;
            if (w_load_ctrl) begin
                E_Control   <= w_e_ctrl;
                W_Control   <= w_w_ctrl;
                Mem_Control <= w_mem_ctrl;
            end
        end else begin
            valid   <= 1'b0;
            illegal <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: doc/decode_stage.md
DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 Parameter ILLEGAL_AS_NOP, default 1, meaning: 1 = unsupported opcodes decode as all-zero controls; 0 = controls held at previous value.
REQ-002 clock  input  1  sole clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-low; low clears all state immediately, independent of clock.
REQ-004 instr_dout  input  16  instruction word from fetch/memory.
REQ-005 npc_in  input  16  next-PC accompanying instr_dout.
REQ-006 Sr  input  3  status bits (N,Z,P) presented with the instruction.
REQ-007 en_decode  input  1  capture enable; inputs sampled only when high.
REQ-008 IR  output  16  registered instruction.
REQ-009 npc_out  output  16  registered npc_in.
REQ-010 psr_out  output  3  registered Sr.
REQ-011 E_Control  output  6  {alu_control[1:0], pcselect1[1:0], pcselect2, op2select}.
REQ-012 W_Control  output  2  writeback select: 0 ALU, 1 memory, 2 PC-relative (LEA).
REQ-013 Mem_Control  output  1  1 for indirect accesses (LDI, STI).
REQ-014 valid  output  1  high the cycle after a capture, low otherwise.
REQ-015 illegal  output  1  high with valid when captured opcode is unsupported.

Function
REQ-016 Rising edge with en_decode=1: IR, npc_out, psr_out, E_Control, W_Control, Mem_Control, illegal registered from current inputs; valid=1. Latency exactly one cycle.
REQ-017 Rising edge with en_decode=0: all data/control outputs hold; valid=0, illegal=0.
REQ-018 Decode on instr_dout[15:12]; E_Control values:
  - ADD 0001: 000001 if instr[5]=0 (register), 000000 if instr[5]=1 (imm5).
  - AND 0101: 010001 if instr[5]=0, 010000 if instr[5]=1.
  - NOT 1001: 100000.
  - BR 0000, LD 0010, LDI 1010, LEA 1110, ST 0011, STI 1011: 000110.
  - LDR 0110, STR 0111: 001000.
  - JMP 1100: 001100.
REQ-019 W_Control: 1 for LD, LDR, LDI; 2 for LEA; 0 for all other supported opcodes.
REQ-020 Mem_Control: 1 for LDI, STI; 0 otherwise.
REQ-021 Unsupported opcodes (0100, 1000, 1101, 1111): illegal=1; IR/npc_out/psr_out still captured; E_Control=0, W_Control=0, Mem_Control=0 when ILLEGAL_AS_NOP=1, else those three hold previous values.
REQ-022 Decode purely from the captured instruction; no dependence on prior instructions except hold behaviour of REQ-017/REQ-021.
REQ-023 Back-to-back en_decode=1: every cycle updates; no bubbles inserted.
REQ-024 X on instr_dout with en_decode=0 does not propagate to outputs.

Reset
REQ-025 reset=0: IR=0, npc_out=0, psr_out=0, E_Control=0, W_Control=0, Mem_Control=0, valid=0, illegal=0, asynchronously.
REQ-026 Reset asserted mid-stream discards any in-progress capture; first capture after release occurs on first rising edge with reset=1 and en_decode=1.
REQ-027 en_decode high during reset has no effect.

Verification
REQ-028 Reset low, then released; en_decode=0 for 3 cycles -> all outputs 0, valid=0 throughout.
REQ-029 en_decode=1, instr_dout=16'h1283 (ADD reg), npc_in=16'h3001, Sr=3'b010 -> next cycle IR=16'h1283, npc_out=16'h3001, psr_out=3'b010, E_Control=6'b000001, W_Control=0, Mem_Control=0, valid=1.
REQ-030 Consecutive captures 16'hA403 (LDI), 16'h6A42 (LDR), 16'hE60F (LEA) -> E_Control 000110/001000/000110, W_Control 1/1/2, Mem_Control 1/0/0, valid high all three cycles.
REQ-031 Capture 16'h5020 (AND imm), then en_decode=0 with instr_dout=16'hFFFF for 4 cycles -> E_Control stays 010000, IR stays 16'h5020, valid=0 after first cycle.
REQ-032 Capture 16'hF025 (TRAP) with ILLEGAL_AS_NOP=1 -> illegal=1, valid=1, E_Control=0, IR=16'hF025; with ILLEGAL_AS_NOP=0 after 16'hC1C0 (JMP) -> E_Control stays 001100.
REQ-033 reset pulsed low between two en_decode=1 edges -> outputs 0 immediately on assertion; next post-release capture decodes correctly.
